dmem_io_param: RTL
==================

Name: dmem_io_param

Overview:
Parametrised successor to the single-cycle CPU's data memory/I-O block. It provides word-addressed data RAM plus a memory-mapped I/O window with:
- N debounced switch inputs, each with sticky rising-edge flags;
- M hex-digit seven-segment display registers;
- a loadable free-running cycle timer.
It sits on the CPU data port: the address is the ALU output, with the usual write/read strobes.

Parameters:
DATA_W, 16, data word width (>= 8)
ADDR_W, 16, address width
DEPTH, 128, RAM words at addresses 0..DEPTH-1 (DEPTH <= IO_BASE)
NUM_SW, 2, switch inputs (1..DATA_W)
NUM_DISP, 1, seven-segment digits (1..8)
IO_BASE, 16'hFFF0, first I/O address (16-word window)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a switch change (>= 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
addr  in  ADDR_W  data address
wdata  in  DATA_W  write data
write  in  1  write enable
read  in  1  read enable
rdata  out  DATA_W  read data
io_sw  in  NUM_SW  raw asynchronous switches
io_display  out  7*NUM_DISP  segments {g,f,e,d,c,b,a} per digit, digit 0 in LSBs, active-high

Behaviour:
- Interface (already decided): one clock `clock`; `reset` is synchronous and active-high.
- I/O map, offset = addr - IO_BASE:
  - 0..NUM_DISP-1: DISP[i], R/W, low 4 bits stored, upper bits read 0.
  - 8: SW_LEVEL, RO, debounced levels in bits NUM_SW-1..0.
  - 9: SW_EDGE, sticky rising-edge flags; writing 1 to a bit clears it.
  - 10: TIMER, R/W.
  - All other offsets, and addresses in neither RAM nor window: read 0, writes ignored.
- Reads are combinational, with zero latency:
  - rdata = selected value when read=1, else 0.
  - Simultaneous read and write returns the pre-write value.
- Writes take effect at the rising edge when write=1.
  - The RAM is not cleared by reset; its initial contents are X.
- Reset (synchronous) clears:
  - DISP[*]=0, so io_display shows "0" = 7'b0111111 per digit;
  - sync flops, debounced levels, debounce counters, SW_EDGE and TIMER = 0.
  - Reset overrides any concurrent write.
- Switch path, per bit:
  - 2-flop synchroniser producing s.
  - Counter cnt increments while s != deb; any cycle with s == deb clears cnt.
  - When s != deb and cnt == DEBOUNCE_CYCLES-1, deb <= s and cnt <= 0.
  - Net latency: deb changes at the edge 1+DEBOUNCE_CYCLES after the first edge that samples the new raw level (5 edges for the default). A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never propagates.
- Edge flag:
  - Set when deb transitions 0->1.
  - A set and a write-1-clear in the same cycle: set wins.
  - A 1->0 transition does not touch the flag.
- TIMER:
  - Increments by 1 every cycle and wraps from all-ones to 0.
  - A write loads wdata, and the increment is suppressed that cycle: next value = wdata exactly.
- Display: each digit's nibble is decoded to a hex glyph. Required glyphs include:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.

Decomposition:
- Shared package: I/O offset constants (OFF_DISP=0, OFF_SW_LEVEL=8, OFF_SW_EDGE=9, OFF_TIMER=10) and the 16-entry glyph constant table.
- One sub-module, seven_seg_decode (4-bit nibble -> 7-bit segments), instantiated NUM_DISP times.
- Debounce logic is a generate loop inside the top module.

Test Plan:
1. Reset, then read IO_BASE+0 and IO_BASE+8 -> rdata=0 for both; io_display=7'b0111111; TIMER read = 0 immediately after reset.
2. Write 16'h1234 to addr 5, then read addr 5 -> 16'h1234. Write to addr DEPTH and to IO_BASE+12 -> both later read 0, RAM[5] unchanged.
3. Write 16'hFFAB to IO_BASE+0 -> readback 16'h000B; io_display=7'h7C. NUM_DISP=2: write 4 to IO_BASE+1 -> io_display[13:7]=7'h66.
4. Raise io_sw[0] and hold -> SW_LEVEL bit0 rises exactly 5 edges later and SW_EDGE=1. A 3-cycle pulse on io_sw[1] -> SW_LEVEL and SW_EDGE bit1 stay 0.
5. Write 16'h0001 to IO_BASE+9 -> SW_EDGE bit0 clears. Repeat the write in the same cycle that a new rising debounced edge occurs -> flag remains 1.
6. Write 16'hFFFE to IO_BASE+10, then read over successive cycles -> FFFE, FFFF, 0000, 0001. Assert reset during a pending write -> TIMER=0, DISP unchanged from 0.

Source files
------------

// File: rtl/dmem_io_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_io_param_pkg
//  Purpose  : Shared constants for the data-memory / I/O block: offsets of
//             the I/O registers inside the 16-word window and the hex glyph
//             table used by the seven-segment decoders.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_io_param_pkg;

   // Register offsets relative to IO_BASE
   localparam logic [3:0] OFF_DISP     = 4'd0;
   localparam logic [3:0] OFF_SW_LEVEL = 4'd8;
   localparam logic [3:0] OFF_SW_EDGE  = 4'd9;
   localparam logic [3:0] OFF_TIMER    = 4'd10;

   // Hex glyphs, segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage
`default_nettype wire

// File: rtl/dmem_io_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_io_param_if
//  Purpose  : CPU data-port bus between the core and the data memory / I/O
//             block.
//  Signals  : addr  - word address (ALU result)
//             wdata - write data
//             write - write strobe
//             read  - read strobe
//             rdata - combinational read data (0 when read is low)
//  Modports : master (CPU side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_io_param_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              write;
   logic              read;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, output wdata, output write, output read, input  rdata);
   modport slave  (input  addr, input  wdata, input  write, input  read, output rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_io_param_seven_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_decode
//  Purpose  : Hex nibble to seven-segment glyph lookup.
//  Ports    : nibble in  4 - value to display
//             seg    out 7 - segments {g,f,e,d,c,b,a}, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decode (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   import dmem_io_param_pkg::*;

   assign seg = GLYPH_TABLE[nibble];
endmodule
`default_nettype wire

// File: rtl/dmem_io_param.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_io_param
//  Purpose  : Word-addressed data RAM plus a 16-word memory-mapped I/O window
//             with debounced switches (level + sticky rising-edge flags),
//             hex seven-segment display registers and a loadable cycle timer.
//  Ports    : clock      in  1           - system clock, rising edge
//             reset      in  1           - synchronous, active-high
//             bus        slave           - addr/wdata/write/read/rdata
//             io_sw      in  NUM_SW      - raw asynchronous switches
//             io_display out 7*NUM_DISP  - segments per digit, digit 0 in LSBs
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_io_param #(
   parameter int                DATA_W          = 16,
   parameter int                ADDR_W          = 16,
   parameter int                DEPTH           = 128,
   parameter int                NUM_SW          = 2,
   parameter int                NUM_DISP        = 1,
   parameter logic [ADDR_W-1:0] IO_BASE         = 16'hFFF0,
   parameter int                DEBOUNCE_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   dmem_io_param_if.slave        bus,
   input  logic [NUM_SW-1:0]     io_sw,
   output logic [7*NUM_DISP-1:0] io_display
);
   import dmem_io_param_pkg::*;

   localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(DEPTH - 1);
   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // ---------------- address decode ----------------
   logic [ADDR_W-1:0] io_off;
   logic [3:0]        off;
   logic              ram_hit;
   logic              io_hit;
   logic [RAM_AW-1:0] ram_idx;

   assign ram_hit = (bus.addr <= RAM_TOP);
   assign ram_idx = bus.addr[RAM_AW-1:0];
   // Wrapping subtraction keeps the window test correct when IO_BASE+16
   // overflows the address width.
   assign io_off  = bus.addr - IO_BASE;
   assign io_hit  = (bus.addr >= IO_BASE) && (io_off[ADDR_W-1:4] == '0);
   assign off     = io_off[3:0];

   logic edge_clr;
   logic timer_wr;
   assign edge_clr = bus.write && io_hit && (off == OFF_SW_EDGE);
   assign timer_wr = bus.write && io_hit && (off == OFF_TIMER);

   // ---------------- RAM (not reset) ----------------
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (!reset && bus.write && ram_hit)
         mem[ram_idx] <= bus.wdata;
   end

   // ---------------- display registers ----------------
   logic [3:0] disp [NUM_DISP];

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_DISP; i++) begin
         if (reset)
            disp[i] <= 4'd0;
         else if (bus.write && io_hit && (off == OFF_DISP + 4'(i)))
            disp[i] <= bus.wdata[3:0];
      end
   end

   for (genvar i = 0; i < NUM_DISP; i++) begin : g_disp
      seven_seg_decode u_dec (
         .nibble (disp[i]),
         .seg    (io_display[7*i +: 7])
      );
   end

   // ---------------- timer ----------------
   logic [DATA_W-1:0] timer;

   always_ff @(posedge clock) begin
      if (reset)
         timer <= '0;
      else if (timer_wr)
         timer <= bus.wdata;
      else
         timer <= timer + 1'b1;
   end

   // ---------------- switch synchronise / debounce / edge ----------------
   logic [NUM_SW-1:0] sw_level;
   logic [NUM_SW-1:0] sw_edge;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      logic             sync1;
      logic             sync2;
      logic             deb;
      logic             flag;
      logic             rise;
      logic [CNT_W-1:0] cnt;

      // deb goes 0->1 at this edge; the flag set takes priority over a clear
      assign rise = sync2 && !deb && (cnt == CNT_MAX);

      always_ff @(posedge clock) begin
         if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
            flag  <= 1'b0;
         end else begin
            sync1 <= io_sw[i];
            sync2 <= sync1;
            if (sync2 != deb) begin
               if (cnt == CNT_MAX) begin
                  deb <= sync2;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end else begin
               cnt <= '0;
            end
            flag <= rise || (flag && !(edge_clr && bus.wdata[i]));
         end
      end

      assign sw_level[i] = deb;
      assign sw_edge[i]  = flag;
   end

   // ---------------- combinational read mux ----------------
   always_comb begin
      bus.rdata = '0;
      if (bus.read) begin
         if (ram_hit) begin
            bus.rdata = mem[ram_idx];
         end else if (io_hit) begin
            for (int i = 0; i < NUM_DISP; i++) begin
               if (off == OFF_DISP + 4'(i))
                  bus.rdata = DATA_W'(disp[i]);
            end
            case (off)
               OFF_SW_LEVEL: bus.rdata = DATA_W'(sw_level);
               OFF_SW_EDGE:  bus.rdata = DATA_W'(sw_edge);
               OFF_TIMER:    bus.rdata = timer;
               default:      ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
